dap_resp_packer: RTL and testbench

//  Response-side stage behind the DAP command workers. Captures response bytes written by the

---
 rtl/dap_resp_packer.sv | 100 ++++++++++
 tb/tb_dap_resp_packer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dap_resp_packer.sv
// dap_resp_packer: ping-pong response packet RAM streamed out as a byte AXI-Stream with an id header
module dap_resp_packer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        cmd_id,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    input  logic              commit,
    input  logic [ADDR_W-1:0] commit_len,
    output logic              commit_ready,
    output logic              resp_tvalid,
    input  logic              resp_tready,
    output logic [7:0]        resp_tdata,
    output logic              resp_tlast
);
    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    state_t            state;
    logic [7:0]        mem [2**(ADDR_W+1)];
    logic [1:0]        full;
    logic              fill_sel;
    logic              send_sel;
    logic [ADDR_W-1:0] len [2];
    logic [7:0]        id [2];
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   idx_inc;
    logic [7:0]        q;
    logic              hs;
    logic              nxt_bank;
    logic              load;
    logic              rd_en;
    logic              wr_ok;
    logic              commit_ok;
    logic [ADDR_W-1:0] rd_addr;

    assign commit_ready = !full[fill_sel];
    assign wr_ok        = wr_en & commit_ready;
    assign commit_ok    = commit & commit_ready;
    assign hs           = resp_tvalid & resp_tready;
    // DONE may start the other bank directly so back-to-back packets get a single gap cycle
    assign nxt_bank     = (state == DONE) ? !send_sel : send_sel;
    assign load         = (state == IDLE || state == DONE) && full[nxt_bank];
    assign idx_inc      = idx + {{ADDR_W{1'b0}}, 1'b1};
    assign rd_addr      = load ? '0 : idx_inc[ADDR_W-1:0];
    assign rd_en        = load | hs;

    // q always holds payload[idx] while a packet is on the wire
    always_ff @(posedge clk) begin
        if (wr_ok) mem[{fill_sel, wr_addr}] <= wr_data;
        if (rd_en) q <= mem[{nxt_bank, rd_addr}];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            full        <= '0;
            fill_sel    <= 1'b0;
            send_sel    <= 1'b0;
            len         <= '{default: '0};
            id          <= '{default: '0};
            idx         <= '0;
            resp_tvalid <= 1'b0;
            resp_tdata  <= '0;
            resp_tlast  <= 1'b0;
        end else begin
            if (commit_ok) begin
                len[fill_sel]  <= commit_len;
                id[fill_sel]   <= cmd_id;
                full[fill_sel] <= 1'b1;
                fill_sel       <= !fill_sel;
            end
            if (state == DONE) begin
                full[send_sel] <= 1'b0;
                send_sel       <= !send_sel;
            end
            if (state == IDLE || state == DONE) begin
                state <= load ? HDR : IDLE;
                if (load) begin
                    resp_tvalid <= 1'b1;
                    resp_tdata  <= id[nxt_bank];
                    resp_tlast  <= len[nxt_bank] == '0;
                    idx         <= '0;
                end
            end else if (hs) begin
                if (resp_tlast) begin
                    resp_tvalid <= 1'b0;
                    state       <= DONE;
                end else begin
                    resp_tdata <= q;
                    resp_tlast <= idx_inc == {1'b0, len[send_sel]};
                    idx        <= idx_inc;
                    state      <= DATA;
                end
            end
        end
    end
endmodule

// File: tb/tb_dap_resp_packer.sv
// tb_dap_resp_packer: random and directed stimulus checked against a packet-queue model
module tb_dap_resp_packer;
    localparam int AW = 10;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    cmd_id = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          wr_en = 1'b0;
    logic          commit = 1'b0;
    logic [AW-1:0] commit_len = '0;
    logic          commit_ready;
    logic          resp_tvalid;
    logic          resp_tready = 1'b0;
    logic [7:0]    resp_tdata;
    logic          resp_tlast;

    always #5 clk = ~clk;

    dap_resp_packer #(.ADDR_W(AW)) dut (
        .clk(clk), .resetn(resetn), .cmd_id(cmd_id), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_en(wr_en), .commit(commit), .commit_len(commit_len), .commit_ready(commit_ready),
        .resp_tvalid(resp_tvalid), .resp_tready(resp_tready), .resp_tdata(resp_tdata),
        .resp_tlast(resp_tlast)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: two banks, a count of occupied banks, and the queue of bytes still owed on the wire
    logic [7:0] mbank [2][N];
    bit         mfill = 1'b0;
    int         occ = 0;
    bit         free_pend = 1'b0;
    logic [8:0] exp_q [$];
    bit         prev_stall = 1'b0;
    logic [8:0] prev_word = '0;
    int         n_hs = 0;
    bit         rnd_rdy = 1'b0;

    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            occ = 0;
            free_pend = 1'b0;
            mfill = 1'b0;
            prev_stall = 1'b0;
        end else begin
            bit do_free;
            bit acc;
            check("commit_ready", commit_ready, occ < 2);
            if (prev_stall) begin
                check("stall_valid", resp_tvalid, 1);
                check("stall_hold", {resp_tlast, resp_tdata}, prev_word);
            end
            if (resp_tvalid) begin
                if (exp_q.size() == 0) check("spurious_valid", resp_tvalid, 0);
                else check("byte", {resp_tlast, resp_tdata}, exp_q[0]);
            end
            prev_stall = resp_tvalid && !resp_tready;
            prev_word = {resp_tlast, resp_tdata};
            do_free = free_pend;
            free_pend = 1'b0;
            if (resp_tvalid && resp_tready && exp_q.size() > 0) begin
                n_hs++;
                free_pend = exp_q[0][8];
                void'(exp_q.pop_front());
            end
            acc = commit && occ < 2;
            if (wr_en && occ < 2) mbank[mfill][wr_addr] = wr_data;
            if (acc) begin
                exp_q.push_back({commit_len == 0, cmd_id});
                for (int i = 0; i < int'(commit_len); i++)
                    exp_q.push_back({i == int'(commit_len) - 1, mbank[mfill][i]});
                mfill = !mfill;
            end
            occ = occ + int'(acc) - int'(do_free);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_rdy) resp_tready = $urandom_range(0, 3) != 0;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic cmt(input logic [7:0] i, input int l);
        commit = 1'b1;
        cmd_id = i;
        commit_len = AW'(l);
        step();
        commit = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 3000 && !commit_ready; i++) step();
        check("ready_timeout", commit_ready, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 8000 && (exp_q.size() != 0 || occ != 0); i++) step();
        check("drain_timeout", exp_q.size(), 0);
    endtask

    logic [7:0] d4 [9] = '{8'h05, 8'hA0, 8'hA1, 8'hA2, 8'h00, 8'h06, 8'hB0, 8'hB1, 8'h00};
    bit         v4 [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
    bit         l4 [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};

    initial begin
        int hs0;
        repeat (3) step();
        resetn = 1'b1;
        step();
        check("rst_tvalid", resp_tvalid, 0);
        check("rst_tlast", resp_tlast, 0);
        check("rst_tdata", resp_tdata, 0);
        check("rst_ready", commit_ready, 1);

        resp_tready = 1'b1;
        wr(0, 8'h00);
        cmt(8'h09, 1);
        check("t2_gap", resp_tvalid, 0);
        step();
        check("t2_hdr", {resp_tvalid, resp_tlast, resp_tdata}, {1'b1, 1'b0, 8'h09});
        step();
        check("t2_pay", {resp_tvalid, resp_tlast, resp_tdata}, {1'b1, 1'b1, 8'h00});
        step();
        check("t2_done", resp_tvalid, 0);
        repeat (2) step();

        cmt(8'h02, 0);
        check("t3_gap", resp_tvalid, 0);
        step();
        check("t3_hdr", {resp_tvalid, resp_tlast, resp_tdata}, {1'b1, 1'b1, 8'h02});
        step();
        check("t3_done", resp_tvalid, 0);
        repeat (2) step();

        resp_tready = 1'b0;
        wr(0, 8'hA0); wr(1, 8'hA1); wr(2, 8'hA2);
        cmt(8'h05, 3);
        wr(0, 8'hB0); wr(1, 8'hB1);
        cmt(8'h06, 2);
        check("t4_full", commit_ready, 0);
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'hEE;
        commit = 1'b1; cmd_id = 8'h07; commit_len = AW'(1);
        step();
        wr_en = 1'b0; commit = 1'b0;
        check("t4_still_full", commit_ready, 0);
        resp_tready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t4_v%0d", i), resp_tvalid, v4[i]);
            if (v4[i]) check($sformatf("t4_b%0d", i), {resp_tlast, resp_tdata}, {l4[i], d4[i]});
            if (i == 4) check("t4_rdy_in_done", commit_ready, 0);
            if (i == 5) check("t4_rdy_after", commit_ready, 1);
            step();
        end
        drain();

        rnd_rdy = 1'b1;
        for (int a = 0; a < 1023; a++) wr(a, 8'(a));
        hs0 = n_hs;
        cmt(8'h5A, 1023);
        drain();
        check("t5_count", n_hs - hs0, 1024);

        for (int p = 0; p < 30; p++) begin
            int l;
            wait_ready();
            l = (p % 5 == 0) ? 0 : int'($urandom_range(1, 40));
            for (int a = 0; a < l; a++) begin
                wr(a, 8'($urandom));
                if ($urandom_range(0, 4) == 0) wr(a, 8'($urandom));
            end
            if ($urandom_range(0, 3) == 0) wr(int'($urandom_range(41, N - 1)), 8'($urandom));
            cmt(8'($urandom), l);
            if (!commit_ready && $urandom_range(0, 1) == 1) begin
                wr(0, 8'hCC);
                cmt(8'hCC, 5);
            end
        end
        drain();

        rnd_rdy = 1'b0;
        resp_tready = 1'b1;
        for (int a = 0; a < 9; a++) wr(a, 8'(8'h10 + a));
        cmt(8'h33, 9);
        for (int i = 0; i < 20 && !resp_tvalid; i++) step();
        check("t6_first", resp_tdata, 8'h33);
        repeat (4) step();
        check("t6_fifth", resp_tdata, 8'h13);
        resetn = 1'b0;
        #1;
        check("t6_async_valid", resp_tvalid, 0);
        check("t6_async_last", resp_tlast, 0);
        repeat (2) step();
        resetn = 1'b1;
        step();
        check("t6_ready", commit_ready, 1);
        repeat (5) begin
            step();
            check("t6_quiet", resp_tvalid, 0);
        end
        wr(0, 8'h77);
        cmt(8'h44, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
